// File: rtl/rcpu_pkg.sv
// Shared RCPU definitions: ALU opcodes, requester IDs and the response payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rcpu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 3;
  localparam int RSP_ID_W = 1;
  localparam int RSP_F_W  = XLEN;

  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 3'b111;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  // Response slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Registered response payload.
  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [RSP_F_W-1:0]  f;
    logic                zf;
    logic                of;
  } rsp_t;

endpackage

// File: rtl/ALU.sv
// 32-bit combinational ALU: logic ops, add/sub with overflow, sltu, left shift.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
module ALU
  import rcpu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     f,
  output logic                zf,
  output logic                of
);

  logic [XLEN-1:0] b_add;
  logic [XLEN:0]   sum;

  // Shared adder (sub = a + ~b + 1), result select and flags.
  always_comb begin
    b_add = (op == ALU_OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_add} + {{XLEN{1'b0}}, (op == ALU_OP_SUB)};
    f     = '0;
    of    = 1'b0;
    case (op)
      ALU_OP_AND:  f = a & b;
      ALU_OP_OR:   f = a | b;
      ALU_OP_XOR:  f = a ^ b;
      ALU_OP_NOR:  f = ~(a | b);
      ALU_OP_ADD, ALU_OP_SUB: begin
        f  = sum[XLEN-1:0];
        // Overflow uses the operand actually fed to the adder (inverted b for sub).
        of = a[XLEN-1] ^ b_add[XLEN-1] ^ sum[XLEN-1] ^ sum[XLEN];
      end
      ALU_OP_SLTU: f = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_OP_SLL:  f = (|a[XLEN-1:5]) ? '0 : (b << a[4:0]);
      default:     f = '0;
    endcase
    zf = (f == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one ALU; result registered into a tagged response slot.
// Latency: 1 cycle from accept edge to rsp_valid; 1 op/cycle with drain+accept overlap.
// Backpressure: readys drop while the slot is full and rsp_ready is low; rsp_* then hold.
module alu_share_arbiter
  import rcpu_pkg::*;
#(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [2:0]          r0_op,
  input  logic [31:0]         r0_a,
  input  logic [31:0]         r0_b,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [2:0]          r1_op,
  input  logic [31:0]         r1_a,
  input  logic [31:0]         r1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [31:0]         rsp_f,
  output logic                rsp_zf,
  output logic                rsp_of,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1
);

  slot_state_e       state_q, state_d;
  rsp_t              rsp_q, rsp_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              can_accept;
  logic              grant0, grant1;
  logic              fire;
  logic              winner;
  logic [2:0]        alu_op;
  logic [31:0]       alu_a, alu_b, alu_f;
  logic              alu_zf, alu_of;

  // Grant: a lone requester wins; on contention rr_ptr (or r0 when fixed) decides.
  always_comb begin
    can_accept = (state_q == SLOT_EMPTY) | rsp_ready;
    if (RR_EN != 0) begin
      grant0 = r0_valid & (~r1_valid | (rr_ptr_q == REQ_R0));
      grant1 = r1_valid & (~r0_valid | (rr_ptr_q == REQ_R1));
    end else begin
      grant0 = r0_valid;
      grant1 = r1_valid & ~r0_valid;
    end
    // Readys are forced low during reset so nothing is accepted on a reset edge.
    r0_ready = grant0 & can_accept & ~rst;
    r1_ready = grant1 & can_accept & ~rst;
    fire     = r0_ready | r1_ready;
    winner   = grant1 ? REQ_R1 : REQ_R0;
  end

  // Winner mux feeding the shared ALU.
  always_comb begin
    alu_op = (winner == REQ_R1) ? r1_op : r0_op;
    alu_a  = (winner == REQ_R1) ? r1_a  : r0_a;
    alu_b  = (winner == REQ_R1) ? r1_b  : r0_b;
  end

  ALU u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .f  (alu_f),
    .zf (alu_zf),
    .of (alu_of)
  );

  // Next state: load on fire (even while draining), empty on drain-only, else hold.
  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    if (fire) begin
      state_d  = SLOT_FULL;
      rsp_d.id = winner;
      rsp_d.f  = alu_f;
      rsp_d.zf = alu_zf;
      rsp_d.of = alu_of;
      rr_ptr_d = ~winner;
      if (winner == REQ_R1) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
    end else if ((state_q == SLOT_FULL) && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Registers with synchronous reset; a pending response is discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      rsp_q    <= '0;
      rr_ptr_q <= REQ_R0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      rr_ptr_q <= rr_ptr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // Registered outputs.
  always_comb begin
    rsp_valid = (state_q == SLOT_FULL);
    rsp_id    = rsp_q.id;
    rsp_f     = rsp_q.f;
    rsp_zf    = rsp_q.zf;
    rsp_of    = rsp_q.of;
    cnt0      = cnt0_q;
    cnt1      = cnt1_q;
  end

endmodule
